// File: rtl/j1_io_pkg.sv
// rtl/j1_io_pkg.sv - register map, status bit positions and UART state encodings
package j1_io_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_BAUD   = 2'd3;

    localparam int ST_TX_FULL      = 0;
    localparam int ST_TX_EMPTY     = 1;
    localparam int ST_RX_VALID     = 2;
    localparam int ST_RX_OVERRUN   = 3;
    localparam int ST_TX_OVERFLOW  = 4;
    localparam int ST_RX_FRAME_ERR = 5;
    localparam int ST_TX_BUSY      = 6;

    typedef enum logic [1:0] {
        U_IDLE  = 2'd0,
        U_START = 2'd1,
        U_DATA  = 2'd2,
        U_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/j1_io_fifo.sv
// rtl/j1_io_fifo.sv - synchronous first-word-fall-through FIFO
module j1_io_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTHLOG2 = 3
) (
    input  logic                 clk,
    input  logic                 resetq,
    input  logic                 push,
    input  logic [WIDTH-1:0]     din,
    input  logic                 pop,
    output logic [WIDTH-1:0]     dout,
    output logic                 full,
    output logic                 empty,
    output logic [DEPTHLOG2:0]   count
);

    logic [WIDTH-1:0]     mem [2**DEPTHLOG2];
    logic [DEPTHLOG2-1:0] wptr;
    logic [DEPTHLOG2-1:0] rptr;
    logic                 do_push;
    logic                 do_pop;

    // A push while full still lands if the same cycle frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = count[DEPTHLOG2];
    assign empty   = (count == '0);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + DEPTHLOG2'(1);
            if (do_pop)  rptr <= rptr + DEPTHLOG2'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (DEPTHLOG2+1)'(1);
                2'b01:   count <= count - (DEPTHLOG2+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/j1_uart_io.sv
// rtl/j1_uart_io.sv - memory-mapped UART on the j1 data port
module j1_uart_io
    import j1_io_pkg::*;
#(
    parameter int                ADDR_W      = 14,
    parameter logic [ADDR_W-1:0] IO_BASE     = 14'h3FF0,
    parameter int                TXDEPTHLOG2 = 3,
    parameter logic [15:0]       DIV_RESET   = 16'd433
) (
    input  logic              clk,
    input  logic              resetq,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic              io_wr,
    input  logic              io_rd,
    input  logic [15:0]       io_din,
    output logic [15:0]       io_dout,
    output logic              io_sel,
    output logic              uart_tx,
    input  logic              uart_rx
);

    logic [ADDR_W-1:0]  off;
    logic [1:0]         reg_off;
    logic               wr_tx, wr_status, wr_baud, rd_rx;
    logic [15:0]        div;
    logic [7:0]         fifo_dout;
    logic               tx_full, tx_empty, tx_pop, tx_drop;
    logic [TXDEPTHLOG2:0] tx_count;
    uart_state_t        tx_state, rx_state;
    logic [15:0]        tx_cnt, tx_div, rx_cnt, rx_div;
    logic [2:0]         tx_bit, rx_bit;
    logic [7:0]         tx_shift, rx_shift, rx_byte;
    logic               rx_s1, rx_s2, rx_prev, rx_done;
    logic               rx_valid, rx_overrun, rx_frame_err, tx_overflow;
    logic [15:0]        status;

    // Addresses below the base wrap to large offsets, so one compare covers both ends.
    assign off       = io_addr - IO_BASE;
    assign io_sel    = (off < ADDR_W'(4));
    assign reg_off   = off[1:0];
    assign wr_tx     = io_wr && io_sel && (reg_off == REG_TXDATA);
    assign wr_status = io_wr && io_sel && (reg_off == REG_STATUS);
    assign wr_baud   = io_wr && io_sel && (reg_off == REG_BAUD);
    assign rd_rx     = io_rd && io_sel && (reg_off == REG_RXDATA);

    assign tx_pop  = !tx_empty && ((tx_state == U_IDLE) ||
                                   ((tx_state == U_STOP) && (tx_cnt == tx_div)));
    assign tx_drop = wr_tx && tx_count[TXDEPTHLOG2] && !tx_pop;
    assign rx_done = (rx_state == U_STOP) && (rx_cnt == rx_div);

    assign status = {9'd0, (tx_state != U_IDLE), rx_frame_err, tx_overflow,
                     rx_overrun, rx_valid, tx_empty, tx_full};

    j1_io_fifo #(.WIDTH(8), .DEPTHLOG2(TXDEPTHLOG2)) u_tx_fifo (
        .clk    (clk),
        .resetq (resetq),
        .push   (wr_tx),
        .din    (io_din[7:0]),
        .pop    (tx_pop),
        .dout   (fifo_dout),
        .full   (tx_full),
        .empty  (tx_empty),
        .count  (tx_count)
    );

    // Each bit latches the divisor at its start so a BAUDDIV write lands on a boundary.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state <= U_IDLE;
            tx_cnt   <= '0;
            tx_div   <= DIV_RESET;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
        end else if (tx_state == U_IDLE) begin
            if (!tx_empty) begin
                tx_state <= U_START;
                tx_shift <= fifo_dout;
                tx_div   <= div;
                tx_cnt   <= '0;
                uart_tx  <= 1'b0;
            end
        end else if (tx_cnt != tx_div) begin
            tx_cnt <= tx_cnt + 16'd1;
        end else begin
            tx_cnt <= '0;
            tx_div <= div;
            case (tx_state)
                U_START: begin
                    tx_state <= U_DATA;
                    tx_bit   <= '0;
                    uart_tx  <= tx_shift[0];
                end
                U_DATA: begin
                    if (tx_bit == 3'd7) begin
                        tx_state <= U_STOP;
                        uart_tx  <= 1'b1;
                    end else begin
                        tx_bit   <= tx_bit + 3'd1;
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        uart_tx  <= tx_shift[1];
                    end
                end
                default: begin
                    if (!tx_empty) begin
                        tx_state <= U_START;
                        tx_shift <= fifo_dout;
                        uart_tx  <= 1'b0;
                    end else begin
                        tx_state <= U_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= U_IDLE;
            rx_cnt   <= '0;
            rx_div   <= DIV_RESET;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            case (rx_state)
                U_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= U_START;
                        rx_cnt   <= '0;
                        rx_div   <= div;
                    end
                end
                U_START: begin
                    if (rx_cnt != {1'b0, rx_div[15:1]}) begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end else if (rx_s2) begin
                        rx_state <= U_IDLE;
                    end else begin
                        rx_state <= U_DATA;
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                    end
                end
                U_DATA: begin
                    if (rx_cnt != rx_div) begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end else begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= U_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end
                end
                default: begin
                    if (rx_cnt != rx_div) rx_cnt <= rx_cnt + 16'd1;
                    else                  rx_state <= U_IDLE;
                end
            endcase
        end
    end

    // Delivery beats a concurrent RXDATA read; the read still returns the old byte.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
            tx_overflow  <= 1'b0;
            div          <= DIV_RESET;
            io_dout      <= '0;
        end else begin
            if (rx_done) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rd_rx) begin
                rx_valid <= 1'b0;
            end
            if (rx_done && rx_valid && !rd_rx)                  rx_overrun <= 1'b1;
            else if (wr_status && io_din[ST_RX_OVERRUN])        rx_overrun <= 1'b0;
            if (rx_done && !rx_s2)                              rx_frame_err <= 1'b1;
            else if (wr_status && io_din[ST_RX_FRAME_ERR])      rx_frame_err <= 1'b0;
            if (tx_drop)                                        tx_overflow <= 1'b1;
            else if (wr_status && io_din[ST_TX_OVERFLOW])       tx_overflow <= 1'b0;
            if (wr_baud) div <= io_din;
            if (io_rd) begin
                if (!io_sel) io_dout <= '0;
                else begin
                    case (reg_off)
                        REG_RXDATA: io_dout <= {8'h00, rx_byte};
                        REG_STATUS: io_dout <= status;
                        REG_BAUD:   io_dout <= div;
                        default:    io_dout <= '0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_j1_uart_io.sv
// tb/tb_j1_uart_io.sv - scoreboard bench for j1_uart_io
module tb_j1_uart_io;
    import j1_io_pkg::*;

    localparam logic [13:0] BASE = 14'h3FF0;

    logic        clk = 1'b0;
    logic        resetq = 1'b0;
    logic [13:0] io_addr = '0;
    logic        io_wr = 1'b0;
    logic        io_rd = 1'b0;
    logic [15:0] io_din = '0;
    logic [15:0] io_dout;
    logic        io_sel;
    logic        uart_tx;
    logic        uart_rx = 1'b1;

    int n_cmp = 0;
    int n_fail = 0;

    logic [15:0] rq_exp[$];
    string       rq_name[$];
    logic [7:0]  tx_exp_q[$];
    logic        rd_d = 1'b0;
    logic        mon_en = 1'b0;
    int          cur_div = 433;

    // Reference model state
    logic        m_rxv, m_ovr, m_frame, m_txovf;
    logic [7:0]  m_rxb;
    logic [15:0] m_div;

    j1_uart_io dut (
        .clk(clk), .resetq(resetq), .io_addr(io_addr), .io_wr(io_wr), .io_rd(io_rd),
        .io_din(io_din), .io_dout(io_dout), .io_sel(io_sel), .uart_tx(uart_tx), .uart_rx(uart_rx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] st(input logic busy, input logic empty, input logic full);
        return {9'd0, busy, m_frame, m_txovf, m_ovr, m_rxv, empty, full};
    endfunction

    function automatic void model_reset();
        m_rxv = 0; m_ovr = 0; m_frame = 0; m_txovf = 0; m_rxb = 8'h00; m_div = 16'd433;
    endfunction

    // One bus cycle, entered and left at posedge+1.
    task automatic op(input logic rd, input logic wr, input logic [13:0] a,
                      input logic [15:0] d, input logic [15:0] exp, input string nm);
        io_addr = a; io_rd = rd; io_wr = wr; io_din = d;
        if (rd) begin rq_exp.push_back(exp); rq_name.push_back(nm); end
        @(posedge clk); #1;
        io_rd = 1'b0; io_wr = 1'b0;
    endtask

    task automatic wr_reg(input logic [1:0] r, input logic [15:0] d);
        op(1'b0, 1'b1, BASE + 14'(r), d, 16'h0, "");
        if (r == REG_BAUD) m_div = d;
    endtask

    task automatic rd_reg(input logic [1:0] r, input logic [15:0] exp, input string nm);
        op(1'b1, 1'b0, BASE + 14'(r), 16'h0, exp, nm);
    endtask

    task automatic set_div(input int d);
        wr_reg(REG_BAUD, 16'(d));
        cur_div = d;
    endtask

    // n TXDATA writes in consecutive cycles from idle: the FIFO plus the byte the
    // serializer takes one cycle later hold DEPTH+1 bytes; the rest are dropped.
    task automatic tx_burst(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (i < 9) tx_exp_q.push_back(b);
            else m_txovf = 1;
            wr_reg(REG_TXDATA, {8'h00, b});
        end
    endtask

    task automatic wait_tx_idle();
        int t = 0;
        while (tx_exp_q.size() != 0 && t < 30000) begin @(posedge clk); t++; end
        if (tx_exp_q.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL tx_drain: %0d frames outstanding, required 0", tx_exp_q.size());
            tx_exp_q.delete();
        end
        repeat (11 * (cur_div + 1) + 4) @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (cur_div + 1) @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
        repeat (cur_div + 4) @(posedge clk);
        #1;
        if (m_rxv) m_ovr = 1;
        m_rxb = b; m_rxv = 1;
        if (!stop) m_frame = 1;
    endtask

    task automatic rd_rxdata(input string nm);
        rd_reg(REG_RXDATA, {8'h00, m_rxb}, nm);
        m_rxv = 0;
    endtask

    // Read-data monitor
    always @(posedge clk) rd_d <= io_rd;
    always @(negedge clk) begin
        if (rd_d) begin
            if (rq_exp.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL rd_unexpected: io_dout %h with no expectation queued", io_dout);
            end else begin
                chk(rq_name.pop_front(), io_dout, rq_exp.pop_front());
            end
        end
    end

    // Serial TX monitor: checks every clock of every bit against the queued byte.
    initial begin : tx_mon
        int d;
        logic [9:0] fr, got;
        logic glitch;
        logic [7:0] eb;
        forever begin
            @(negedge clk);
            if (mon_en && resetq && uart_tx === 1'b0) begin
                d = cur_div; glitch = 1'b0; got = '0;
                if (tx_exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL tx_unexpected_frame: start bit seen, required idle line");
                    eb = 8'h00;
                end else begin
                    eb = tx_exp_q.pop_front();
                end
                fr = {1'b1, eb, 1'b0};
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c <= d; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (c == 0) got[b] = uart_tx;
                        else if (uart_tx !== got[b]) glitch = 1'b1;
                    end
                end
                chk("tx_frame", 16'({glitch, got}), 16'({1'b0, fr}));
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [13:0] a;
        logic [7:0]  b1, b2;
        int          bursts [3];
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_uart_tx", 16'(uart_tx), 16'h0001);
        chk("reset_io_dout", io_dout, 16'h0000);
        @(negedge clk); resetq = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        rd_reg(REG_STATUS, 16'h0002, "reset_status");
        rd_reg(REG_BAUD, 16'd433, "reset_bauddiv");
        op(1'b1, 1'b0, BASE + 14'd4, 16'h0, 16'h0000, "read_outside_window");

        for (int i = 0; i < 10; i++) begin
            case (i)
                0: a = BASE - 14'd1;  1: a = BASE;  2: a = BASE + 14'd3;
                3: a = BASE + 14'd4;  4: a = 14'h0000; 5: a = 14'h3FFF;
                default: a = 14'($urandom);
            endcase
            io_addr = a; #1;
            chk("io_sel", 16'(io_sel), 16'((a >= 14'h3FF0) && (a <= 14'h3FF3)));
        end
        @(posedge clk); #1;

        op(1'b0, 1'b1, BASE - 14'd1, 16'h1234, 16'h0, "");
        op(1'b0, 1'b1, BASE + 14'd7, 16'h4321, 16'h0, "");
        rd_reg(REG_BAUD, 16'd433, "bauddiv_after_outside_writes");

        // Single frame: busy for 10*(div+1) clocks beginning the cycle after the push.
        set_div(3);
        rd_reg(REG_BAUD, 16'd3, "bauddiv_write");
        tx_exp_q.push_back(8'hA5);
        wr_reg(REG_TXDATA, 16'h00A5);
        for (int n = 1; n <= 45; n++)
            rd_reg(REG_STATUS, st(n >= 2 && n <= 41, n != 1, 1'b0), "tx_busy_window");
        wait_tx_idle();
        rd_reg(REG_STATUS, 16'h0002, "status_after_tx");

        bursts[0] = 9; bursts[1] = 10; bursts[2] = $urandom_range(1, 12);
        for (int k = 0; k < 3; k++) begin
            set_div($urandom_range(0, 5));
            tx_burst(bursts[k]);
            wait_tx_idle();
            rd_reg(REG_STATUS, st(0, 1, 0), "status_after_burst");
            if (m_txovf) begin
                wr_reg(REG_STATUS, 16'h0010);
                m_txovf = 0;
                rd_reg(REG_STATUS, st(0, 1, 0), "status_ovf_cleared");
            end
        end

        // Receive path
        set_div(7);
        send_rx(8'h3C, 1'b1);
        rd_reg(REG_STATUS, st(0, 1, 0), "status_rx_valid");
        rd_rxdata("rxdata_3c");
        rd_reg(REG_STATUS, st(0, 1, 0), "status_rx_cleared");

        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        rd_rxdata("rxdata_overrun");
        rd_reg(REG_STATUS, st(0, 1, 0), "status_overrun");
        b1 = 8'($urandom);
        send_rx(b1, 1'b0);
        rd_reg(REG_STATUS, st(0, 1, 0), "status_frame_err");
        op(1'b1, 1'b1, BASE + 14'(REG_STATUS), 16'h0038, st(0, 1, 0), "status_w1c_preclear");
        m_ovr = 0; m_frame = 0; m_txovf = 0;
        rd_reg(REG_STATUS, st(0, 1, 0), "status_w1c_cleared");
        rd_rxdata("rxdata_frame_err_byte");

        for (int k = 0; k < 3; k++) begin
            set_div($urandom_range(3, 9));
            b1 = 8'($urandom); b2 = 8'($urandom);
            send_rx(b1, 1'b1);
            if ($urandom_range(0, 1) == 1) rd_rxdata("rxdata_random_first");
            send_rx(b2, 1'b1);
            rd_reg(REG_STATUS, st(0, 1, 0), "status_random_rx");
            rd_rxdata("rxdata_random_second");
            wr_reg(REG_STATUS, 16'h0038);
            m_ovr = 0; m_frame = 0;
        end

        set_div(7);
        uart_rx = 1'b0;
        @(posedge clk); #1;
        uart_rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rd_reg(REG_STATUS, st(0, 1, 0), "status_after_glitch");
        rd_reg(REG_RXDATA, {8'h00, m_rxb}, "rxdata_after_glitch");

        // Reset in the middle of TX and RX frames with a full FIFO and a sticky flag set.
        mon_en = 1'b0;
        set_div(3);
        for (int i = 0; i < 10; i++) wr_reg(REG_TXDATA, 16'(i + 1));
        repeat (12) @(posedge clk);
        #1;
        uart_rx = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        resetq = 1'b0;
        #1;
        chk("reset_mid_frame_uart_tx", 16'(uart_tx), 16'h0001);
        chk("reset_mid_frame_io_dout", io_dout, 16'h0000);
        uart_rx = 1'b1;
        tx_exp_q.delete();
        model_reset();
        cur_div = 433;
        repeat (3) @(negedge clk);
        resetq = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        rd_reg(REG_STATUS, 16'h0002, "status_after_mid_reset");
        rd_reg(REG_BAUD, 16'd433, "bauddiv_after_mid_reset");
        rd_reg(REG_RXDATA, 16'h0000, "rxdata_after_mid_reset");
        repeat (60) @(posedge clk);
        #1;
        chk("uart_tx_idle_after_reset", 16'(uart_tx), 16'h0001);

        repeat (4) @(posedge clk);
        #1;
        chk("rd_queue_drained", 16'(rq_exp.size()), 16'h0000);
        chk("tx_queue_drained", 16'(tx_exp_q.size()), 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
